// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 mid-bit sampling receiver with one-entry holding register
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta, rxs;
    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             good_n, bad_n, good_p, bad_p;
    logic             tick, hold, load;

    assign tick = cnt == '0;
    assign hold = rx_valid & ~rx_ready;
    assign load = good_p & ~hold;

    // Two-flop synchroniser; the line idles high so both flops reset to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Frame state machine: counter reaching zero marks each mid-bit sample point
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        good_n  = 1'b0;
        bad_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n = S_START;
                    cnt_n   = HALF;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (rxs) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DATA;
                    cnt_n   = FULL;
                    idx_n   = 3'd0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    shreg_n = {rxs, shreg[7:1]};
                    cnt_n   = FULL;
                    idx_n   = idx + 3'd1;
                    state_n = (idx == 3'd7) ? S_STOP : S_DATA;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    good_n  = rxs;
                    bad_n   = ~rxs;
                    state_n = rxs ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: state_n = rxs ? S_IDLE : S_BREAK;
            default: state_n = S_IDLE;
        endcase
    end

    // State registers; busy is registered alongside state so it never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= 3'd0;
            shreg  <= 8'd0;
            good_p <= 1'b0;
            bad_p  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            good_p <= good_n;
            bad_p  <= bad_n;
            busy   <= state_n != S_IDLE;
        end
    end

    // Holding register: a full, undrained register keeps its byte and flags the loss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_data   <= load ? shreg : rx_data;
            rx_valid  <= load | hold;
            frame_err <= bad_p;
            overrun   <= good_p & hold;
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed table, corner sequences and random model check
module tb_uart_rx_sampler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx_sampler #(.CLKS_PER_BIT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         ok;
        bit         rdy;
        bit         e_valid;
        logic [7:0] e_data;
        int         e_fe;
        int         e_ov;
    } vec_t;

    typedef struct {
        int         at;
        bit         good;
        logic [7:0] d;
    } ev_t;

    vec_t       tbl[8];
    ev_t        evq[$];
    logic [7:0] got[$];
    int         checks = 0, failures = 0;
    int         fe_cnt = 0, ov_cnt = 0, sc = 0, rdy_pct = 0;
    bit         busy_seen = 0, model_on = 0, rand_rdy = 0, col = 0;
    bit         mv = 0, e_fe = 0, e_ov = 0;
    logic [7:0] md = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bit-clock of line drive: edge sc happens, outputs are sampled, then rx for the next cycle is set
    task automatic step(input logic v);
        bit   rdy_q, e_good, ld;
        logic [7:0] e_d;
        ev_t  ev;
        @(posedge clk);
        rdy_q = rx_ready;
        e_good = 0;
        e_d = 8'd0;
        e_fe = 0;
        while (evq.size() > 0 && evq[0].at == sc) begin
            ev = evq.pop_front();
            if (ev.good) begin
                e_good = 1;
                e_d = ev.d;
            end else e_fe = 1;
        end
        e_ov = e_good && mv && !rdy_q;
        ld = e_good && !(mv && !rdy_q);
        if (ld) md = e_d;
        mv = ld || (mv && !rdy_q);
        #1;
        if (model_on) chk("rand", {21'd0, rx_valid, rx_data, frame_err, overrun}, {21'd0, mv, md, e_fe, e_ov});
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (busy) busy_seen = 1;
        if (col && rx_valid && rx_ready) got.push_back(rx_data);
        rx = v;
        if (rand_rdy) rx_ready = ($urandom_range(0, 99) < rdy_pct);
        sc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1);
    endtask

    // Start bit, 8 data bits LSB first, stop bit; a bad stop is followed by `hold` extra low cycles
    task automatic send(input logic [7:0] d, input bit ok, input int hold);
        if (model_on) evq.push_back('{sc + 80, ok, d});
        repeat (8) step(1'b0);
        for (int i = 0; i < 8; i++) repeat (8) step(d[i]);
        repeat (8) step(ok);
        if (!ok) repeat (hold) step(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1, 0, 1, 8'hA5, 0, 0};
        tbl[1] = '{8'h3C, 0, 0, 1, 8'hA5, 1, 0};
        tbl[2] = '{8'h5A, 1, 0, 1, 8'hA5, 0, 1};
        tbl[3] = '{8'h5A, 1, 1, 0, 8'h5A, 0, 0};
        tbl[4] = '{8'hFF, 1, 0, 1, 8'hFF, 0, 0};
        tbl[5] = '{8'h00, 1, 1, 0, 8'h00, 0, 0};
        tbl[6] = '{8'h00, 0, 1, 0, 8'h00, 1, 0};
        tbl[7] = '{8'h80, 1, 0, 1, 8'h80, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 8; i++) begin
            rx_ready = tbl[i].rdy;
            fe_cnt = 0;
            ov_cnt = 0;
            send(tbl[i].d, tbl[i].ok, 10);
            idle(6);
            rx_ready = 1'b0;
            chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_fe", i), fe_cnt, tbl[i].e_fe);
            chk($sformatf("tbl%0d_ov", i), ov_cnt, tbl[i].e_ov);
        end

        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(3);
        send(8'hA5, 1, 0);
        chk("a5_at_stop_sample", rx_valid, 0);
        idle(1);
        chk("a5_valid_rise", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        chk("a5_drained", rx_valid, 0);
        chk("a5_data_held", rx_data, 8'hA5);

        idle(4);
        fe_cnt = 0;
        busy_seen = 0;
        repeat (2) step(1'b0);
        idle(20);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_fe", fe_cnt, 0);

        fe_cnt = 0;
        send(8'h3C, 0, 40);
        chk("brk_fe", fe_cnt, 1);
        chk("brk_busy_low", busy, 1);
        chk("brk_valid", rx_valid, 0);
        idle(6);
        chk("brk_busy_released", busy, 0);

        ov_cnt = 0;
        send(8'h11, 1, 0);
        send(8'h22, 1, 0);
        idle(4);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_pulses", ov_cnt, 1);
        ov_cnt = 0;
        send(8'h33, 1, 0);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        chk("swap_data", rx_data, 8'h33);
        chk("swap_valid", rx_valid, 1);
        chk("swap_ov", ov_cnt, 0);

        idle(4);
        repeat (8) step(1'b0);
        repeat (35) step(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", rx_valid, 0);
        chk("async_data", rx_data, 0);
        chk("async_busy", busy, 0);
        chk("async_fe_ov", {frame_err, overrun}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rx = 1'b1;
        fe_cnt = 0;
        idle(5);
        chk("post_rst_valid", rx_valid, 0);
        send(8'h5A, 1, 0);
        idle(4);
        chk("post_rst_data", rx_data, 8'h5A);
        chk("post_rst_valid2", rx_valid, 1);
        chk("post_rst_fe", fe_cnt, 0);

        rx_ready = 1'b1;
        idle(2);
        got.delete();
        col = 1;
        fe_cnt = 0;
        ov_cnt = 0;
        for (int b = 0; b < 16; b++) send(8'(b), 1, 0);
        idle(6);
        col = 0;
        rx_ready = 1'b0;
        chk("stream_count", got.size(), 16);
        for (int b = 0; b < 16 && b < got.size(); b++) chk($sformatf("stream_%0d", b), got[b], b);
        chk("stream_flags", {fe_cnt[15:0], ov_cnt[15:0]}, 0);

        do_reset();
        evq.delete();
        mv = 0;
        md = 8'd0;
        model_on = 1;
        rand_rdy = 1;
        for (int f = 0; f < 40; f++) begin
            bit ok;
            ok = $urandom_range(0, 7) != 0;
            case ($urandom_range(0, 2))
                0: rdy_pct = 0;
                1: rdy_pct = 2;
                default: rdy_pct = 50;
            endcase
            idle($urandom_range(0, 3));
            send(8'($urandom_range(0, 255)), ok, $urandom_range(0, 20));
            if (!ok) idle(2 + $urandom_range(0, 3));
        end
        idle(100);
        chk("rand_events_drained", evq.size(), 0);
        model_on = 0;
        rand_rdy = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial receive front end for the board's `rx` pin, directly downstream of the top-level pad and feeding the monitor/loader command path inside `fpga_top`. It synchronises the asynchronous line, finds 8N1 frames by mid-bit sampling at a fixed bit period, and presents each good byte in a one-entry holding register with a valid/ready handshake. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); minimum legal value 4.
- `CNT_W`, default 9: bit-period counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts byte when `rx_valid`&`rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte arrived while holding register full and not being drained.
- `busy`  out  1  state machine not in IDLE.

## Operation
- Input sync: two flops, reset to 1; `rxs` = second flop. All decisions use `rxs` only.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rxs`=0 load counter with CLKS_PER_BIT/2 - 1 (integer division), go START.
- START: count down; at 0 sample `rxs`. If 0: reload CLKS_PER_BIT-1, bit index=0, go DATA. If 1: glitch, return IDLE, no flag.
- DATA: count down; at 0 shift `rxs` into shift register LSB first (bit 0 first), reload counter; after bit index 7 go STOP.
- STOP: count down; at 0 sample `rxs`. If 1: byte good, go IDLE. If 0: pulse `frame_err`, discard byte, go BREAK.
- BREAK: wait for `rxs`=1, then IDLE (no new frame detected while line held low).
- Holding register: good byte loads `rx_data` and sets `rx_valid` unless `rx_valid`=1 and `rx_ready`=0, in which case old byte kept, new byte dropped, `overrun` pulses.
- `rx_valid` clears on `rx_valid`&`rx_ready` with no simultaneous load.
- Simultaneous drain and good-byte load: new byte replaces old, `rx_valid` stays 1, no overrun.
- `rx_data` changes only on load; holds last value after drain.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0; state IDLE, sync flops 1, counter 0, shift register 0.
- Reset mid-frame aborts immediately; after release the block waits in IDLE for a falling edge. A partially received frame is never delivered.
- `rx` falling edge to START entry: 3 clocks (2 sync + IDLE detect).
- Start sample at CLKS_PER_BIT/2 cycles after START entry; each data and stop sample CLKS_PER_BIT cycles after the previous.
- `rx_valid` (or `frame_err`/`overrun`) asserts on the clock edge following the stop-bit sample; pulses last exactly one cycle.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit beginning at the nominal stop-bit end is detected.
- `busy` = 1 in every state except IDLE, registered with state.

## Test plan
- CLKS_PER_BIT=8: send 0xA5 8N1 with `rx_ready`=0 -> `rx_valid` rises 1 cycle after stop sample, `rx_data`=0xA5; then `rx_ready`=1 one cycle -> `rx_valid`=0, `rx_data` stays 0xA5.
- Glitch: `rx` low for 2 cycles then high -> START rejects, returns IDLE, no `rx_valid`, no `frame_err`.
- Framing: send 0x3C with stop bit low, then hold low 40 cycles -> one `frame_err` pulse, `rx_valid` stays 0, `busy`=1 until `rx` returns high.
- Overrun: send 0x11 then 0x22 back-to-back, `rx_ready`=0 -> `rx_data`=0x11, one `overrun` pulse at second byte; send 0x33 with `rx_ready`=1 held at load cycle -> `rx_data`=0x33, `rx_valid`=1, no overrun.
- Reset mid-frame: assert `rst` during data bit 4 of 0xFF -> all outputs 0 asynchronously; after release, full 0x5A frame -> `rx_data`=0x5A, no error.
- Stream: 16 consecutive bytes 0x00..0x0F, no idle gap, `rx_ready`=1 -> all 16 delivered in order, no flags.
